btn_conditioner: RTL

- Front-end stage between the five Basys 3 push-buttons and the clock/alarm control FSM.
- Synchronises and debounces each raw button and emits one-clock press pulses.
- Guarantees the pulse vector is one-hot or zero, which the FSM's exact-pattern decode requires.
- Supports hold-to-repeat on the Up/Down buttons so hours and minutes can be scrolled while a button is held.

---
 rtl/btn_pkg.sv | 36 +++
 rtl/btn_if.sv | 26 ++
 rtl/btn_channel.sv | 115 +++++++++++
 rtl/btn_conditioner.sv | 77 +++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared definitions for the push-button front end: button indices, channel
// state encoding and default timing constants.
package btn_pkg;

    localparam int BTN_C = 0;
    localparam int BTN_L = 1;
    localparam int BTN_R = 2;
    localparam int BTN_D = 3;
    localparam int BTN_U = 4;

    localparam int          DEF_NUM_BTN            = 5;
    localparam int          DEF_TICK_DIV           = 500000;
    localparam int          DEF_DEBOUNCE_TICKS     = 4;
    localparam int          DEF_REPEAT_DELAY_TICKS = 100;
    localparam int          DEF_REPEAT_RATE_TICKS  = 20;
    localparam logic [4:0]  DEF_REPEAT_MASK        = 5'b11000;

`ifdef BTN_AUTOREPEAT_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HELD   = 2'd1,
        REPEAT = 2'd2
    } chan_state_t;
`else
    typedef enum logic {
        IDLE = 1'b0,
        HELD = 1'b1
    } chan_state_t;
`endif

    // Bits needed to hold any value in 0..max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/btn_if.sv
// Button bundle between the raw pins, the conditioner and the control FSM.
interface btn_if #(
    parameter int NUM_BTN = 5
) ();
    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] btn_level;
    logic [NUM_BTN-1:0] press_pulse;
    logic               any_press;
    logic               tick;

    modport master (
        output btn_raw,
        input  btn_level,
        input  press_pulse,
        input  any_press,
        input  tick
    );

    modport slave (
        input  btn_raw,
        output btn_level,
        output press_pulse,
        output any_press,
        output tick
    );
endinterface

// File: rtl/btn_channel.sv
// One button channel: 2-flop synchroniser, tick-based debounce and press FSM.
// Hold-to-repeat logic exists only when BTN_AUTOREPEAT_EN is defined.
module btn_channel
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS
`ifdef BTN_AUTOREPEAT_EN
    ,
    parameter int REPEAT_DELAY_TICKS = DEF_REPEAT_DELAY_TICKS,
    parameter int REPEAT_RATE_TICKS  = DEF_REPEAT_RATE_TICKS,
    parameter bit REPEAT_EN          = 1'b0
`endif
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    input  logic tick,
    output logic level,
    output logic evt
);

    localparam int               DEB_W    = cnt_width(DEBOUNCE_TICKS);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_TICKS - 1);

    logic [1:0]       sync_reg;
    logic             sync;
    chan_state_t      state_reg, state_next;
    logic [DEB_W-1:0] deb_reg, deb_next;

`ifdef BTN_AUTOREPEAT_EN
    localparam int                HOLD_W    = cnt_width(REPEAT_DELAY_TICKS);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(REPEAT_DELAY_TICKS - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(REPEAT_DELAY_TICKS);
    localparam int                REP_W     = cnt_width(REPEAT_RATE_TICKS);
    localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_RATE_TICKS - 1);

    logic [HOLD_W-1:0] hold_reg, hold_next;
    logic [REP_W-1:0]  rep_reg, rep_next;
`endif

    assign sync  = sync_reg[1];
    assign level = (state_reg != IDLE);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_reg  <= '0;
            state_reg <= IDLE;
            deb_reg   <= '0;
`ifdef BTN_AUTOREPEAT_EN
            hold_reg  <= '0;
            rep_reg   <= '0;
`endif
        end else begin
            sync_reg  <= {sync_reg[0], raw};
            state_reg <= state_next;
            deb_reg   <= deb_next;
`ifdef BTN_AUTOREPEAT_EN
            hold_reg  <= hold_next;
            rep_reg   <= rep_next;
`endif
        end
    end

    always_comb begin
        state_next = state_reg;
        deb_next   = deb_reg;
        evt        = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
        hold_next  = hold_reg;
        rep_next   = rep_reg;
`endif
        if (tick) begin
            if (sync != level) begin
                if (deb_reg == DEB_LAST) begin
                    deb_next = '0;
                    if (level) begin
                        state_next = IDLE;
`ifdef BTN_AUTOREPEAT_EN
                        hold_next  = '0;
                        rep_next   = '0;
`endif
                    end else begin
                        state_next = HELD;
                        evt        = 1'b1;
                    end
                end else begin
                    deb_next = deb_reg + 1'b1;
                end
            end else begin
                deb_next = '0;
`ifdef BTN_AUTOREPEAT_EN
                // Repeat timing only advances on ticks that see the button down,
                // so a pending release can never emit a late repeat.
                if (state_reg == HELD) begin
                    if (REPEAT_EN && (hold_reg == HOLD_LAST)) begin
                        state_next = REPEAT;
                        evt        = 1'b1;
                        hold_next  = '0;
                    end else if (hold_reg != HOLD_MAX) begin
                        hold_next = hold_reg + 1'b1;
                    end
                end else if (state_reg == REPEAT) begin
                    if (rep_reg == REP_LAST) begin
                        evt      = 1'b1;
                        rep_next = '0;
                    end else begin
                        rep_next = rep_reg + 1'b1;
                    end
                end
`endif
            end
        end
    end

endmodule

// File: rtl/btn_conditioner.sv
// Push-button front end: sample tick, per-button debounce channels and a
// one-hot press arbiter. Define BTN_AUTOREPEAT_EN to build hold-to-repeat.
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int                 NUM_BTN            = DEF_NUM_BTN,
    parameter int                 TICK_DIV           = DEF_TICK_DIV,
    parameter int                 DEBOUNCE_TICKS     = DEF_DEBOUNCE_TICKS,
    parameter int                 REPEAT_DELAY_TICKS = DEF_REPEAT_DELAY_TICKS,
    parameter int                 REPEAT_RATE_TICKS  = DEF_REPEAT_RATE_TICKS,
    parameter logic [NUM_BTN-1:0] REPEAT_MASK        = NUM_BTN'(DEF_REPEAT_MASK)
) (
    input  logic  clk,
    input  logic  reset_n,
    btn_if.slave  btn
);

    localparam int                TICK_W    = cnt_width(TICK_DIV - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

    logic [TICK_W-1:0]  tick_cnt_reg;
    logic               tick;
    logic [NUM_BTN-1:0] level;
    logic [NUM_BTN-1:0] evt;
    logic [NUM_BTN-1:0] grant;
    logic [NUM_BTN-1:0] press_pulse_reg;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tick_cnt_reg <= '0;
        end else if (tick) begin
            tick_cnt_reg <= '0;
        end else begin
            tick_cnt_reg <= tick_cnt_reg + 1'b1;
        end
    end

    assign tick = (tick_cnt_reg == TICK_LAST);

    generate
        for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_chan
            btn_channel #(
                .DEBOUNCE_TICKS     (DEBOUNCE_TICKS)
`ifdef BTN_AUTOREPEAT_EN
                ,
                .REPEAT_DELAY_TICKS (REPEAT_DELAY_TICKS),
                .REPEAT_RATE_TICKS  (REPEAT_RATE_TICKS),
                .REPEAT_EN          (REPEAT_MASK[gi])
`endif
            ) u_chan (
                .clk     (clk),
                .reset_n (reset_n),
                .raw     (btn.btn_raw[gi]),
                .tick    (tick),
                .level   (level[gi]),
                .evt     (evt[gi])
            );
        end
    endgenerate

    // Isolate the lowest set bit: lowest index wins, the rest are dropped.
    assign grant = evt & (~evt + 1'b1);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            press_pulse_reg <= '0;
        end else begin
            press_pulse_reg <= grant;
        end
    end

    assign btn.btn_level   = level;
    assign btn.press_pulse = press_pulse_reg;
    assign btn.any_press   = |press_pulse_reg;
    assign btn.tick        = tick;

endmodule
